// File: rtl/tcdm_bank_responder_pkg.sv
// Shared types for the TCDM bank responder and its AMO ALU.
//   amo_op_e      : 4-bit atomic opcode encoding carried on req_amo_i
//   resp_state_e  : responder FSM states
//   SC_SUCCESS/SC_FAIL : store-conditional result words
//   is_rmw_op     : true for opcodes that occupy the writeback slot
package tcdm_bank_responder_pkg;

  typedef enum logic [3:0] {
    AMO_NONE = 4'd0,
    AMO_SWAP = 4'd1,
    AMO_ADD  = 4'd2,
    AMO_AND  = 4'd3,
    AMO_OR   = 4'd4,
    AMO_XOR  = 4'd5,
    AMO_MAX  = 4'd6,
    AMO_MAXU = 4'd7,
    AMO_MIN  = 4'd8,
    AMO_MINU = 4'd9,
    AMO_LR   = 4'd10,
    AMO_SC   = 4'd11
  } amo_op_e;

  typedef enum logic {ST_IDLE, ST_AMO_WB} resp_state_e;

  localparam logic [31:0] SC_SUCCESS = 32'd0;
  localparam logic [31:0] SC_FAIL    = 32'd1;

  // Arithmetic AMOs always take the writeback slot; SC only when LR/SC exists.
  // LR and opcodes 12-15 are serviced as plain reads.
  function automatic logic is_rmw_op(input logic [3:0] op, input logic lrsc_en);
    return ((op >= 4'd1) && (op <= 4'd9)) || (lrsc_en && (op == AMO_SC));
  endfunction

endpackage

// File: rtl/tcdm_amo_alu.sv
// Combinational AMO ALU: computes the value written back for an atomic.
//   op      : amo opcode (amo_op_e encoding)
//   old_val : value read from memory
//   operand : request operand
//   result  : new memory value (old_val for non-arithmetic opcodes)
module tcdm_amo_alu
  import tcdm_bank_responder_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic [3:0]           op,
  input  logic [DataWidth-1:0] old_val,
  input  logic [DataWidth-1:0] operand,
  output logic [DataWidth-1:0] result
);

  logic slt, ult;
  assign slt = $signed(old_val) < $signed(operand);
  assign ult = old_val < operand;

  always_comb begin
    result = old_val;
    case (op)
      AMO_SWAP: result = operand;
      AMO_ADD:  result = old_val + operand;
      AMO_AND:  result = old_val & operand;
      AMO_OR:   result = old_val | operand;
      AMO_XOR:  result = old_val ^ operand;
      AMO_MAX:  result = slt ? operand : old_val;
      AMO_MAXU: result = ult ? operand : old_val;
      AMO_MIN:  result = slt ? old_val : operand;
      AMO_MINU: result = ult ? old_val : operand;
      default:  result = old_val;
    endcase
  end

endmodule

// File: rtl/tcdm_bank_responder.sv
// TCDM bank responder: serves plain reads/writes and atomics (locked
// read-modify-write) in front of one single-port SRAM bank with 1-cycle
// read latency. Responses are returned in acceptance order through a
// fall-through FIFO; credits (FIFO occupancy + read in flight) gate
// acceptance of anything that produces a response.
// Optional: define TCDM_BANK_LRSC_EN for LR/SC with a single reservation.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_*                    request channel (valid/ready)
//   resp_*                   response channel (valid/ready), rdata + echoed id
//   bank_*                   SRAM port; bank_rdata_i valid cycle after a read
module tcdm_bank_responder
  import tcdm_bank_responder_pkg::*;
#(
  parameter int unsigned BankAddrWidth = 10,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned MetaIdWidth   = 3,
  parameter int unsigned RespDepth     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [BankAddrWidth-1:0] req_tgt_addr_i,
  input  logic                     req_wen_i,
  input  logic [DataWidth-1:0]     req_wdata_i,
  input  logic [3:0]               req_amo_i,
  input  logic [MetaIdWidth-1:0]   req_id_i,
  input  logic [DataWidth/8-1:0]   req_be_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [DataWidth-1:0]     resp_rdata_o,
  output logic [MetaIdWidth-1:0]   resp_id_o,
  output logic                     bank_req_o,
  output logic                     bank_we_o,
  output logic [BankAddrWidth-1:0] bank_addr_o,
  output logic [DataWidth-1:0]     bank_wdata_o,
  output logic [DataWidth/8-1:0]   bank_be_o,
  input  logic [DataWidth-1:0]     bank_rdata_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned CntW      = $clog2(RespDepth + 1);
  localparam int unsigned PtrW      = (RespDepth > 1) ? $clog2(RespDepth) : 1;

`ifdef TCDM_BANK_LRSC_EN
  localparam logic LrscEn = 1'b1;
`else
  localparam logic LrscEn = 1'b0;
`endif

  if (DataWidth != 32) begin : g_bad_width
    $fatal(1, "tcdm_bank_responder: only DataWidth=32 is supported");
  end
  if (RespDepth < 1) begin : g_bad_depth
    $fatal(1, "tcdm_bank_responder: RespDepth must be >= 1");
  end

  resp_state_e state_q, state_d;

  // Latched request for the read in flight / AMO writeback
  logic                     pend_q;
  logic [MetaIdWidth-1:0]   id_q;
  logic [BankAddrWidth-1:0] addr_q;
  logic [DataWidth-1:0]     opnd_q;
  logic [3:0]               op_q;
  logic [StrbWidth-1:0]     be_q;

  logic is_write, is_rmw, credits_ok, accept, rd_issue;
  logic sc_cycle, sc_ok;
  logic [DataWidth-1:0] alu_res;
  logic [CntW:0]        used;

  // Response FIFO
  logic [DataWidth-1:0]   mem_data [RespDepth];
  logic [MetaIdWidth-1:0] mem_id   [RespDepth];
  logic [CntW-1:0]        count_q, count_d;
  logic [PtrW-1:0]        rptr_q, wptr_q;
  logic                   fifo_empty, push, pop, store, take;
  logic [DataWidth-1:0]   push_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RespDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- request side ----------------
  assign is_write   = (req_amo_i == AMO_NONE) && req_wen_i;
  assign is_rmw     = is_rmw_op(req_amo_i, LrscEn);
  assign used       = {1'b0, count_q} + {{CntW{1'b0}}, pend_q};
  assign credits_ok = used < (CntW + 1)'(RespDepth);
  assign req_ready_o = (state_q == ST_IDLE) && (is_write || credits_ok);
  assign accept     = req_valid_i && req_ready_o && !rst_i;
  assign rd_issue   = accept && !is_write;
  assign sc_cycle   = LrscEn && (state_q == ST_AMO_WB) && (op_q == AMO_SC);

  tcdm_amo_alu #(.DataWidth(DataWidth)) i_alu (
    .op      (op_q),
    .old_val (bank_rdata_i),
    .operand (opnd_q),
    .result  (alu_res)
  );

  always_comb begin
    state_d      = state_q;
    bank_req_o   = 1'b0;
    bank_we_o    = 1'b0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          bank_req_o  = 1'b1;
          bank_addr_o = req_tgt_addr_i;
          if (is_write) begin
            bank_we_o    = 1'b1;
            bank_wdata_o = req_wdata_i;
            bank_be_o    = req_be_i;
          end
          if (is_rmw) state_d = ST_AMO_WB;
        end
      end
      ST_AMO_WB: begin
        state_d = ST_IDLE;
        if (sc_cycle) begin
          if (sc_ok) begin
            bank_req_o   = 1'b1;
            bank_we_o    = 1'b1;
            bank_addr_o  = addr_q;
            bank_wdata_o = opnd_q;
            bank_be_o    = be_q;
          end
        end else begin
          bank_req_o   = 1'b1;
          bank_we_o    = 1'b1;
          bank_addr_o  = addr_q;
          bank_wdata_o = alu_res;
          bank_be_o    = '1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset mid-AMO must not let the writeback reach the bank
    if (rst_i) begin
      bank_req_o   = 1'b0;
      bank_we_o    = 1'b0;
      bank_addr_o  = '0;
      bank_wdata_o = '0;
      bank_be_o    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= rd_issue;
      if (rd_issue) begin
        id_q   <= req_id_i;
        addr_q <= req_tgt_addr_i;
        opnd_q <= req_wdata_i;
        op_q   <= req_amo_i;
        be_q   <= req_be_i;
      end
    end
  end

  // ---------------- LR/SC reservation ----------------
`ifdef TCDM_BANK_LRSC_EN
  logic                     res_valid_q;
  logic [BankAddrWidth-1:0] res_addr_q;

  assign sc_ok = res_valid_q && (res_addr_q == addr_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
    end else begin
      if (sc_cycle || (bank_req_o && bank_we_o && (bank_addr_o == res_addr_q)))
        res_valid_q <= 1'b0;
      if (accept && (req_amo_i == AMO_LR)) begin
        res_valid_q <= 1'b1;
        res_addr_q  <= req_tgt_addr_i;
      end
    end
  end
`else
  assign sc_ok = 1'b0;
`endif

  // ---------------- response FIFO (fall-through) ----------------
  // Data from a bank read (plain or AMO) lands the cycle after issue.
  assign push       = pend_q && !rst_i;
  assign push_data  = sc_cycle ? (sc_ok ? SC_SUCCESS : SC_FAIL) : bank_rdata_i;
  assign fifo_empty = (count_q == '0);

  assign resp_valid_o = !rst_i && (push || !fifo_empty);
  assign resp_rdata_o = fifo_empty ? push_data : mem_data[rptr_q];
  assign resp_id_o    = fifo_empty ? id_q      : mem_id[rptr_q];

  assign pop   = resp_valid_o && resp_ready_i;
  assign take  = pop && !fifo_empty;
  // An empty FIFO popped in the same cycle passes the push straight through
  assign store = push && !(fifo_empty && pop);

  always_comb begin
    count_d = count_q;
    if (store && !take)      count_d = count_q + 1'b1;
    else if (take && !store) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
    end else begin
      count_q <= count_d;
      if (store) wptr_q <= ptr_inc(wptr_q);
      if (take)  rptr_q <= ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) begin
      mem_data[wptr_q] <= push_data;
      mem_id[wptr_q]   <= id_q;
    end
  end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
module tb_tcdm_bank_responder;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_wen_i;
  logic [9:0]  req_tgt_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_amo_i, req_be_i;
  logic [2:0]  req_id_i;
  logic        resp_valid_o, resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic [2:0]  resp_id_o;
  logic        bank_req_o, bank_we_o;
  logic [9:0]  bank_addr_o;
  logic [31:0] bank_wdata_o, bank_rdata_i;
  logic [3:0]  bank_be_o;

  always #5 clk = ~clk;

  tcdm_bank_responder dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_tgt_addr_i(req_tgt_addr_i), .req_wen_i(req_wen_i),
    .req_wdata_i(req_wdata_i), .req_amo_i(req_amo_i),
    .req_id_i(req_id_i), .req_be_i(req_be_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_id_o(resp_id_o),
    .bank_req_o(bank_req_o), .bank_we_o(bank_we_o),
    .bank_addr_o(bank_addr_o), .bank_wdata_o(bank_wdata_o),
    .bank_be_o(bank_be_o), .bank_rdata_i(bank_rdata_i)
  );

  // SRAM environment: 1-cycle read latency
  logic [31:0] sram [1024];
  initial for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
  always @(posedge clk) begin
    if (bank_req_o) begin
      if (bank_we_o) begin
        for (int i = 0; i < 4; i++)
          if (bank_be_o[i]) sram[bank_addr_o][8*i +: 8] <= bank_wdata_o[8*i +: 8];
      end else begin
        bank_rdata_i <= sram[bank_addr_o];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] d; logic [2:0] id; } rsp_t;
  rsp_t        expq[$];
  rsp_t        mon_e;
  logic [2:0]  popped[$];
  logic [31:0] ref_mem [1024];
  initial for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
`ifdef TCDM_BANK_LRSC_EN
  bit          res_v = 0;
  logic [9:0]  res_a = '0;
`endif

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  // Semantics of one accepted request, applied atomically in acceptance order
  function automatic void model_accept();
    logic [9:0]  a   = req_tgt_addr_i;
    logic [31:0] old = ref_mem[a];
    logic [31:0] w   = req_wdata_i;
    logic [31:0] rsp = old;
    logic [31:0] nv  = old;
    bit          rmw = 1'b1;
    case (req_amo_i)
      4'd0: begin
        rmw = 1'b0;
        if (req_wen_i) begin
          ref_mem[a] = merge(old, w, req_be_i);
`ifdef TCDM_BANK_LRSC_EN
          if (res_a == a) res_v = 1'b0;
`endif
          return;
        end
      end
      4'd1: nv = w;
      4'd2: nv = old + w;
      4'd3: nv = old & w;
      4'd4: nv = old | w;
      4'd5: nv = old ^ w;
      4'd6: nv = ($signed(old) >= $signed(w)) ? old : w;
      4'd7: nv = (old >= w) ? old : w;
      4'd8: nv = ($signed(old) <= $signed(w)) ? old : w;
      4'd9: nv = (old <= w) ? old : w;
`ifdef TCDM_BANK_LRSC_EN
      4'd10: begin rmw = 1'b0; res_v = 1'b1; res_a = a; end
      4'd11: begin
        rmw = 1'b0;
        if (res_v && res_a == a) begin ref_mem[a] = merge(old, w, req_be_i); rsp = 32'd0; end
        else rsp = 32'd1;
        res_v = 1'b0;
      end
`endif
      default: rmw = 1'b0;
    endcase
    if (rmw) begin
      ref_mem[a] = nv;
`ifdef TCDM_BANK_LRSC_EN
      if (res_a == a) res_v = 1'b0;
`endif
    end
    expq.push_back('{d: rsp, id: req_id_i});
  endfunction

  always @(negedge clk) begin
    if (rst_i) begin
      expq.delete();
`ifdef TCDM_BANK_LRSC_EN
      res_v = 1'b0;
`endif
    end else begin
      if (resp_valid_o && resp_ready_i) begin
        popped.push_back(resp_id_o);
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: got %h id %0d, want no response", resp_rdata_o, resp_id_o);
        end else begin
          mon_e = expq.pop_front();
          chk("model_rdata", resp_rdata_o, mon_e.d);
          chk("model_id", {29'b0, resp_id_o}, {29'b0, mon_e.id});
        end
      end
      if (req_valid_i && req_ready_o) model_accept();
    end
  end

  // ---------------- directed helpers ----------------
  task automatic drive(input logic [3:0] amo, input logic wen, input logic [9:0] a,
                       input logic [31:0] wd, input logic [3:0] be, input logic [2:0] id);
    req_valid_i = 1'b1; req_amo_i = amo; req_wen_i = wen; req_tgt_addr_i = a;
    req_wdata_i = wd; req_be_i = be; req_id_i = id;
  endtask

  task automatic do_req(input logic [3:0] amo, input logic wen, input logic [9:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input logic [2:0] id,
                        input logic has_resp, input logic busy, input logic [31:0] exp, input string nm);
    int n = 0;
    @(posedge clk); #1;
    drive(amo, wen, a, wd, be, id);
    @(negedge clk);
    while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
    if (!req_ready_o) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    if (has_resp) begin
      @(negedge clk);
      chk({nm, "_valid"}, {31'b0, resp_valid_o}, 32'd1);
      chk({nm, "_rdata"}, resp_rdata_o, exp);
      chk({nm, "_id"}, {29'b0, resp_id_o}, {29'b0, id});
      if (busy) chk({nm, "_ready_in_wb"}, {31'b0, req_ready_o}, 32'd0);
    end
  endtask

  typedef struct {
    logic [3:0] amo; logic wen; logic [9:0] a; logic [31:0] wd; logic [3:0] be;
    logic [2:0] id; logic has_resp; logic busy; logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] amo, input logic wen, input logic [9:0] a,
                              input logic [31:0] wd, input logic [3:0] be, input logic [2:0] id,
                              input logic has_resp, input logic busy, input logic [31:0] exp);
    vec_t v;
    v.amo = amo; v.wen = wen; v.a = a; v.wd = wd; v.be = be; v.id = id;
    v.has_resp = has_resp; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                amo    wen  addr  wdata          be     id  resp busy expected
    tbl[0]  = mk(4'd0,  1, 5, 32'hDEADBEEF, 4'h3, 0, 0, 0, 32'h0);
    tbl[1]  = mk(4'd0,  0, 5, 32'h0,        4'hF, 3, 1, 0, 32'h0000BEEF);
    tbl[2]  = mk(4'd0,  1, 7, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 32'h0);
    tbl[3]  = mk(4'd2,  0, 7, 32'h1,        4'hF, 5, 1, 1, 32'hFFFFFFFF);
    tbl[4]  = mk(4'd0,  0, 7, 32'h0,        4'hF, 6, 1, 0, 32'h00000000);
    tbl[5]  = mk(4'd0,  1, 9, 32'h80000000, 4'hF, 0, 0, 0, 32'h0);
    tbl[6]  = mk(4'd6,  0, 9, 32'h1,        4'hF, 1, 1, 1, 32'h80000000);
    tbl[7]  = mk(4'd0,  0, 9, 32'h0,        4'hF, 2, 1, 0, 32'h00000001);
    tbl[8]  = mk(4'd0,  1, 9, 32'h80000000, 4'hF, 0, 0, 0, 32'h0);
    tbl[9]  = mk(4'd7,  0, 9, 32'h1,        4'hF, 4, 1, 1, 32'h80000000);
    tbl[10] = mk(4'd0,  0, 9, 32'h0,        4'hF, 7, 1, 0, 32'h80000000);
    tbl[11] = mk(4'd1,  0, 9, 32'h12345678, 4'hF, 2, 1, 1, 32'h80000000);
    tbl[12] = mk(4'd5,  0, 9, 32'hFFFF0000, 4'hF, 3, 1, 1, 32'h12345678);
    tbl[13] = mk(4'd13, 0, 9, 32'h0,        4'hF, 4, 1, 0, 32'hEDCB5678);
`ifdef TCDM_BANK_LRSC_EN
    tbl[14] = mk(4'd11, 0, 9, 32'h0,        4'hF, 5, 1, 1, 32'h00000001);
`else
    tbl[14] = mk(4'd11, 0, 9, 32'h0,        4'hF, 5, 1, 0, 32'hEDCB5678);
`endif
    tbl[15] = mk(4'd0,  0, 9, 32'h0,        4'hF, 6, 1, 0, 32'hEDCB5678);

    rst_i = 1'b1; resp_ready_i = 1'b1;
    req_valid_i = 1'b0; req_amo_i = '0; req_wen_i = 1'b0; req_tgt_addr_i = '0;
    req_wdata_i = '0; req_be_i = '0; req_id_i = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    chk("rst_bank_req",   {31'b0, bank_req_o},   32'd0);
    chk("rst_bank_we",    {31'b0, bank_we_o},    32'd0);
    chk("rst_ready",      {31'b0, req_ready_o},  32'd1);
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    chk("post_rst_bank_addr",  {22'b0, bank_addr_o},  32'd0);

    // table-driven directed vectors
    for (int i = 0; i < 16; i++)
      do_req(tbl[i].amo, tbl[i].wen, tbl[i].a, tbl[i].wd, tbl[i].be, tbl[i].id,
             tbl[i].has_resp, tbl[i].busy, tbl[i].exp, $sformatf("vec%0d", i));

    // backpressure: two credits, third read stalls, write still goes
    @(posedge clk); #1;
    resp_ready_i = 1'b0; popped.delete();
    drive(4'd0, 0, 5, 0, 4'hF, 0);
    @(negedge clk); chk("bp_rd0_ready", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk); #1 drive(4'd0, 0, 7, 0, 4'hF, 1);
    @(negedge clk); chk("bp_rd1_ready", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk); #1 drive(4'd0, 0, 9, 0, 4'hF, 2);
    @(negedge clk); chk("bp_rd2_stall", {31'b0, req_ready_o}, 32'd0);
    @(posedge clk); #1 drive(4'd0, 1, 12, 32'h77, 4'hF, 3);
    @(negedge clk); chk("bp_write_ready", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk); #1 drive(4'd0, 0, 9, 0, 4'hF, 2); resp_ready_i = 1'b1;
    @(negedge clk); chk("bp_no_same_cycle_credit", {31'b0, req_ready_o}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("bp_rd2_accept", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk); #1 req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_resp_count", popped.size(), 32'd3);
    for (int i = 0; i < 3 && i < popped.size(); i++)
      chk($sformatf("bp_order%0d", i), {29'b0, popped[i]}, i);

    // reset during AMO writeback
    do_req(4'd0, 1, 11, 32'h5, 4'hF, 0, 0, 0, 32'h0, "rstwb_init");
    @(posedge clk); #1 drive(4'd2, 0, 11, 32'h1, 4'hF, 4);
    @(negedge clk); chk("rstwb_accept", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk); #1 req_valid_i = 1'b0; rst_i = 1'b1;
    @(negedge clk);
    chk("rstwb_no_bank_req", {31'b0, bank_req_o}, 32'd0);
    chk("rstwb_no_bank_we",  {31'b0, bank_we_o},  32'd0);
    @(posedge clk); #1 rst_i = 1'b0;
    ref_mem[11] = 32'h5;  // aborted writeback leaves memory untouched
    @(negedge clk); chk("rstwb_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    do_req(4'd0, 0, 11, 0, 4'hF, 5, 1, 0, 32'h5, "rstwb_read");

`ifdef TCDM_BANK_LRSC_EN
    do_req(4'd10, 0, 3, 0,            4'hF, 1, 1, 0, 32'h0,      "lr1");
    do_req(4'd11, 0, 3, 32'hAAAA5555, 4'hF, 2, 1, 1, 32'h0,      "sc_ok");
    do_req(4'd0,  0, 3, 0,            4'hF, 3, 1, 0, 32'hAAAA5555, "sc_ok_rd");
    do_req(4'd10, 0, 3, 0,            4'hF, 4, 1, 0, 32'hAAAA5555, "lr2");
    do_req(4'd0,  1, 3, 32'h1,        4'hF, 0, 0, 0, 32'h0,      "lr2_wr");
    do_req(4'd11, 0, 3, 32'h2,        4'hF, 5, 1, 1, 32'h1,      "sc_fail");
    do_req(4'd0,  0, 3, 0,            4'hF, 6, 1, 0, 32'h1,      "sc_fail_rd");
`endif

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      req_valid_i    = ($urandom_range(0, 9) < 7);
      req_amo_i      = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      req_wen_i      = $urandom_range(0, 1) != 0;
      req_tgt_addr_i = 10'($urandom_range(0, 15));
      req_wdata_i    = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + 32'($urandom_range(0, 2)) : $urandom;
      req_be_i       = 4'($urandom_range(0, 15));
      req_id_i       = 3'($urandom_range(0, 7));
      resp_ready_i   = $urandom_range(0, 3) != 0;
    end
    @(posedge clk); #1 req_valid_i = 1'b0; resp_ready_i = 1'b1;
    for (int n = 0; n < 50 && expq.size() != 0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain_empty", expq.size(), 32'd0);
    for (int a = 0; a < 16; a++)
      chk($sformatf("mem%0d", a), sram[a], ref_mem[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
